mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single-port matrix storage RAM between up to NREQ requesters: input (0), generator (1), calculator (2) and display/result output (3).
- Round-robin arbitration with burst ownership, so a requester keeps the port while streaming a matrix.
- Optional burst cap so the calculator or display cannot starve others.
- Sits between the subsystem modules and the storage RAM, replacing ad-hoc state-based muxing of the storage port.

Parameters:
- NREQ, 4, number of requesters (2..4).
- AW, 10, RAM address width.
- DW, 8, RAM data width.
- MAX_BURST, 16, max accesses per grant while another request is pending; 0 = unlimited.

Ports:
- clk  in  1  system clock. Interface: one clock; reset is synchronous and active-high.
- rst  in  1  synchronous active-high reset.
- req  in  NREQ  per-requester access request; held high for the whole burst.
- req_we  in  NREQ  per-requester write enable for the current access.
- req_addr  in  NREQ*AW  requester i address at [i*AW +: AW].
- req_wdata  in  NREQ*DW  requester i write data at [i*DW +: DW].
- gnt  out  NREQ  one-hot grant, registered.
- rd_valid  out  NREQ  one-hot, 1-cycle pulse; read data valid for that requester.
- rd_data  out  DW  equals mem_rdata; meaningful only when rd_valid is nonzero.
- mem_en  out  1  RAM access strobe.
- mem_we  out  1  RAM write enable.
- mem_addr  out  AW  RAM address.
- mem_wdata  out  DW  RAM write data.
- mem_rdata  in  DW  RAM read data, synchronous, 1-cycle latency.
- owner  out  2  index of the current/last grantee.
- busy  out  1  high while in GRANT.

Behaviour:
- Reset values: gnt=0, rd_valid=0, owner=0, busy=0, burst counter=0, RR pointer=0, state IDLE. mem_en=0 and mem_we=0 follow because the mem_* outputs are decoded from gnt.
- Reset mid-burst: the access in the reset cycle is dropped and any in-flight rd_valid is discarded.
- States:
  - IDLE: no grant.
  - GRANT: gnt[owner]=1.
- IDLE → GRANT:
  - Any req bit high: winner = first set bit searching from RR pointer upward, mod NREQ.
  - gnt[winner] rises the next cycle. Latency req→gnt = 1 cycle.
- Access cycle:
  - Occurs when gnt[i] & req[i] in the same cycle.
  - mem_en=1, mem_we=req_we[i], mem_addr/mem_wdata = slice i (combinational from gnt).
  - A requester that sees gnt low performs no access and must hold req/addr/data.
- Read pulse: each read access produces rd_valid[i] exactly one cycle later.
  - The pulse goes to the original requester even if gnt has already moved.
- GRANT → release: req[owner] low.
  - That cycle performs no access.
  - If other req bits are pending, the next winner is chosen the same cycle and its gnt rises next cycle: direct handoff, no IDLE cycle. Otherwise go to IDLE.
- Burst cap:
  - The counter increments per access and clears on each new grant.
  - If MAX_BURST≠0, the counter reaches MAX_BURST, and any other req bit is high: gnt[owner] drops after that access, and the next winner is granted the following cycle.
  - The preempted requester keeps req high, waits, and rejoins with lowest priority.
  - With no competitor, the cap is ignored and the burst continues indefinitely.
- Fairness: on every grant, RR pointer ← (winner+1) mod NREQ.
- Arbitration inputs: req bits at index ≥ NREQ do not exist. Simultaneous requests are resolved only by the RR pointer; no fixed priority.
- At most one gnt bit high at any time. mem_en=0 whenever no grantee has req high.

Test Plan:
- Reset, RAM preloaded addr 0..2 = 0x11,0x22,0x33; req[0] reads addrs 0,1,2:
  - gnt[0] rises 1 cycle after req.
  - mem_addr = 0,1,2 on consecutive cycles.
  - rd_valid[0] pulses 3 cycles with rd_data 0x11,0x22,0x33.
- From reset, req[1] and req[3] rise together, 2 accesses each:
  - gnt[1] first; on req[1] drop, gnt[3] next cycle with no IDLE.
  - Repeating the pair grants 1 again (pointer = 0 after grant to 3).
- MAX_BURST=4: req[2] writes 0x40..0x49 to addrs 0..9; req[0] pending from cycle 2:
  - gnt[2] drops after the 4th write; gnt[0] next cycle.
  - After req[0] finishes, req[2] resumes at addr 4.
  - Final RAM[0..9] = 0x40..0x49.
- MAX_BURST=4, lone req[3] for 20 reads: no preemption; 20 consecutive mem_en cycles and 20 rd_valid[3] pulses.
- Read on the last capped cycle of requester 2 with requester 1 waiting: rd_valid[2] pulses in the same cycle gnt[1] rises; rd_valid[1] stays low.
- Assert rst for 1 cycle mid-write burst:
  - Next cycle gnt=0, mem_en=0, rd_valid=0, busy=0.
  - With req[2] still high, gnt[2] returns 1 cycle after rst deasserts.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin owner of the single-port storage RAM: bursts keep the port until req drops,
// optionally capped at MAX_BURST accesses while another requester waits.
module mem_port_arbiter #(
  parameter int NREQ      = 4,
  parameter int AW        = 10,
  parameter int DW        = 8,
  parameter int MAX_BURST = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    rd_valid,
  output logic [DW-1:0]      rd_data,
  output logic               mem_en,
  output logic               mem_we,
  output logic [AW-1:0]      mem_addr,
  output logic [DW-1:0]      mem_wdata,
  input  logic [DW-1:0]      mem_rdata,
  output logic [1:0]         owner,
  output logic               busy
);
  localparam int CW = $clog2(MAX_BURST + 2);
  localparam logic [CW-1:0] CAP = CW'(MAX_BURST);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] rd_valid_q, rd_valid_d;
  logic [1:0]      owner_q, owner_d;
  logic [1:0]      rr_q, rr_d;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic            own_req, own_we, cap_hit;
  logic [NREQ-1:0] others;
  logic [2:0]      win;

  // Returns {found, index} of the first set bit at or above ptr, wrapping at NREQ.
  function automatic logic [2:0] pick(input logic [NREQ-1:0] v, input logic [1:0] ptr);
    logic [2:0] res;
    int         idx;
    res = 3'b000;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NREQ;
      if (v[idx]) res = {1'b1, idx[1:0]};
    end
    return res;
  endfunction

  assign own_req = |(gnt_q & req);
  assign own_we  = |(gnt_q & req & req_we);
  assign others  = req & ~gnt_q;
  assign cnt_inc = (cnt_q == CAP) ? cnt_q : cnt_q + CW'(1);
  assign cap_hit = (MAX_BURST != 0) && (cnt_inc == CAP) && (|others);

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_q[i]) begin
        mem_addr  = req_addr[i*AW +: AW];
        mem_wdata = req_wdata[i*DW +: DW];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    owner_d    = owner_q;
    rr_d       = rr_q;
    cnt_d      = cnt_q;
    rd_valid_d = '0;
    win        = 3'b000;
    if (!own_req)     win = pick(req, rr_q);
    else if (cap_hit) win = pick(others, rr_q);
    if (own_req) begin
      cnt_d = cnt_inc;
      if (!own_we) rd_valid_d = gnt_q;
    end
    if (win[2]) begin
      state_d             = GRANT;
      gnt_d               = '0;
      gnt_d[win[1:0]]     = 1'b1;
      owner_d             = win[1:0];
      rr_d                = (int'(win[1:0]) == NREQ - 1) ? 2'd0 : win[1:0] + 2'd1;
      cnt_d               = '0;
    end else if (!own_req) begin
      state_d = IDLE;
      gnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      rd_valid_q <= '0;
      owner_q    <= 2'd0;
      rr_q       <= 2'd0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      rd_valid_q <= rd_valid_d;
      owner_q    <= owner_d;
      rr_q       <= rr_d;
      cnt_q      <= cnt_d;
    end
  end

  // The access presented during a reset cycle never reaches the RAM.
  assign mem_en   = own_req & ~rst;
  assign mem_we   = own_we & ~rst;
  assign gnt      = gnt_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = mem_rdata;
  assign owner    = owner_q;
  assign busy     = (state_q == GRANT);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Per-requester op queues drive traffic; a grant-level model checks arbitration every cycle
// and a monitor pops expected read data as rd_valid pulses arrive.
module tb_mem_port_arbiter;
  localparam int NREQ = 4;
  localparam int AW   = 10;
  localparam int DW   = 8;
  localparam int MAXB = 4;

  typedef struct { int idle; logic we; logic [AW-1:0] addr; logic [DW-1:0] data; } op_t;
  typedef struct { int cyc; logic [DW-1:0] data; } exp_t;

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req, req_we;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    gnt, rd_valid;
  logic [DW-1:0]      rd_data, mem_wdata, mem_rdata;
  logic               mem_en, mem_we, busy;
  logic [AW-1:0]      mem_addr;
  logic [1:0]         owner;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  op_t  opq[NREQ][$];
  exp_t exp_q[NREQ][$];
  int   glog[$];
  logic [NREQ-1:0] rvlog[$];
  logic [NREQ-1:0] cons_v = '0;
  int   n_acc[NREQ];
  int   en_cnt = 0;
  int   rv3_cnt = 0;

  mem_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .MAX_BURST(MAXB)) dut (
    .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .rd_valid(rd_valid), .rd_data(rd_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .owner(owner), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] pre_val(input logic [AW-1:0] a);
    case (a)
      10'd0:   return 8'h11;
      10'd1:   return 8'h22;
      10'd2:   return 8'h33;
      default: return a[7:0] ^ 8'hA5;
    endcase
  endfunction

  // Behavioural RAM: unwritten words read back their preload value.
  logic [DW-1:0] ram [1024];
  bit            ram_wr [1024];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        ram[mem_addr]    <= mem_wdata;
        ram_wr[mem_addr] <= 1'b1;
      end else begin
        mem_rdata <= ram_wr[mem_addr] ? ram[mem_addr] : pre_val(mem_addr);
      end
    end
  end

  function automatic logic [DW-1:0] ram_val(input logic [AW-1:0] a);
    return ram_wr[a] ? ram[a] : pre_val(a);
  endfunction

  function automatic int pick(input logic [NREQ-1:0] v, input int rr);
    for (int k = 0; k < NREQ; k++)
      if (v[(rr + k) % NREQ]) return (rr + k) % NREQ;
    return -1;
  endfunction

  // Sampler: arbitration model, bus checks, and scoreboard pushes on each accepted access.
  initial begin
    logic [NREQ-1:0] m_gnt, oth, prev_gnt;
    int              m_owner, m_rr, m_cnt, w;
    logic            exp_en;
    logic [AW-1:0]   a;
    logic [DW-1:0]   shadow [1024];
    bit              sh_wr [1024];
    m_gnt = '0; m_owner = 0; m_rr = 0; m_cnt = 0; prev_gnt = '0;
    for (int i = 0; i < NREQ; i++) n_acc[i] = 0;
    forever begin
      @(negedge clk);
      exp_en = ((m_gnt & req) != '0) && !rst;
      chk("gnt", gnt, m_gnt);
      chk("busy", busy, m_gnt != '0);
      chk("owner", owner, m_owner);
      chk("mem_en", mem_en, exp_en);
      if (exp_en) begin
        chk("mem_we", mem_we, req_we[m_owner]);
        chk("mem_addr", mem_addr, req_addr[m_owner*AW +: AW]);
        if (req_we[m_owner]) chk("mem_wdata", mem_wdata, req_wdata[m_owner*DW +: DW]);
      end
      if (gnt != '0 && gnt != prev_gnt) begin
        for (int i = 0; i < NREQ; i++) if (gnt[i]) glog.push_back(i);
        rvlog.push_back(rd_valid);
      end
      prev_gnt = gnt;
      en_cnt  += int'(mem_en);
      rv3_cnt += int'(rd_valid[3]);

      cons_v = gnt & req & {NREQ{~rst}};
      for (int i = 0; i < NREQ; i++) begin
        if (cons_v[i]) begin
          a = req_addr[i*AW +: AW];
          n_acc[i]++;
          if (req_we[i]) begin
            shadow[a] = req_wdata[i*DW +: DW];
            sh_wr[a]  = 1'b1;
          end else begin
            exp_q[i].push_back('{cyc: cyc + 1, data: (sh_wr[a] ? shadow[a] : pre_val(a))});
          end
        end
      end

      if (rst) begin
        m_gnt = '0; m_owner = 0; m_rr = 0; m_cnt = 0;
      end else begin
        w = -1;
        if (m_gnt == '0 || !req[m_owner]) begin
          w = pick(req, m_rr);
          if (w < 0) m_gnt = '0;
        end else begin
          m_cnt++;
          oth = req;
          oth[m_owner] = 1'b0;
          if (MAXB != 0 && m_cnt >= MAXB && oth != '0) w = pick(oth, m_rr);
        end
        if (w >= 0) begin
          m_gnt = '0; m_gnt[w] = 1'b1; m_owner = w; m_rr = (w + 1) % NREQ; m_cnt = 0;
        end
      end
    end
  end

  // Monitor: each read must return exactly one cycle after its access, to its own requester.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
        if (exp_q[i].size() > 0 && exp_q[i][0].cyc == cyc) begin
          e = exp_q[i].pop_front();
          chk($sformatf("rd_valid[%0d]", i), rd_valid[i], 1'b1);
          if (rd_valid[i]) chk($sformatf("rd_data[%0d]", i), rd_data, e.data);
        end else begin
          chk($sformatf("rd_valid_idle[%0d]", i), rd_valid[i], 1'b0);
        end
      end
    end
  end

  // Driver: a requester holds its op until it sees its access accepted.
  initial begin
    op_t o;
    req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < NREQ; i++) begin
        if (cons_v[i] && opq[i].size() > 0) void'(opq[i].pop_front());
        if (opq[i].size() == 0) begin
          req[i] = 1'b0;
        end else begin
          o = opq[i][0];
          if (o.idle > 0) begin
            req[i] = 1'b0;
            o.idle--;
            opq[i][0] = o;
          end else begin
            req[i] = 1'b1;
            req_we[i] = o.we;
            req_addr[i*AW +: AW] = o.addr;
            req_wdata[i*DW +: DW] = o.data;
          end
        end
      end
    end
  end

  task automatic push_op(input int r, input int idle, input logic we, input int addr, input int data);
    opq[r].push_back('{idle: idle, we: we, addr: AW'(addr), data: DW'(data)});
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < NREQ; i++) if (opq[i].size() != 0 || exp_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (n < budget && !(all_empty() && req == '0 && gnt == '0)) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_completes"}, n < budget, 1'b1);
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic chk_glog(input string name, input int g0, input int e0, input int e1, input int e2, input int e3, input int n);
    int ev[4];
    ev = '{e0, e1, e2, e3};
    chk({name, "_ngrants"}, glog.size() - g0, n);
    for (int k = 0; k < n; k++)
      if (g0 + k < glog.size()) chk($sformatf("%s_grant%0d", name, k), glog[g0 + k], ev[k]);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g0, e0, r0, n, a0;
    logic [DW-1:0] wd [8];
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_gnt", gnt, 0);
    chk("reset_rd_valid", rd_valid, 0);
    chk("reset_owner", owner, 0);
    chk("reset_busy", busy, 0);
    chk("reset_mem_en", mem_en, 0);

    // Preloaded reads by requester 0.
    g0 = glog.size();
    for (int k = 0; k < 3; k++) push_op(0, 0, 1'b0, k, 0);
    wait_idle("s1", 100);
    chk_glog("s1", g0, 0, 0, 0, 0, 1);

    // Simultaneous requesters 1 and 3, twice.
    pulse_reset();
    g0 = glog.size();
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < 2; k++) begin
        push_op(1, 0, 1'b0, 100 + k, 0);
        push_op(3, 0, 1'b0, 200 + k, 0);
      end
      wait_idle("s2", 100);
    end
    chk_glog("s2", g0, 1, 3, 1, 3, 4);

    // Capped write burst by 2, preempted by a late request from 0.
    g0 = glog.size();
    for (int k = 0; k < 10; k++) push_op(2, 0, 1'b1, k, 8'h40 + k);
    for (int k = 0; k < 3; k++) push_op(0, (k == 0) ? 2 : 0, 1'b0, 20 + k, 0);
    wait_idle("s3", 200);
    chk_glog("s3", g0, 2, 0, 2, 0, 3);
    for (int k = 0; k < 10; k++) chk($sformatf("s3_ram[%0d]", k), ram_val(AW'(k)), 8'h40 + k);

    // Lone requester ignores the cap.
    g0 = glog.size(); e0 = en_cnt; r0 = rv3_cnt;
    for (int k = 0; k < 20; k++) push_op(3, 0, 1'b0, 300 + k, 0);
    wait_idle("s4", 200);
    chk_glog("s4", g0, 3, 0, 0, 0, 1);
    chk("s4_mem_en_cycles", en_cnt - e0, 20);
    chk("s4_rd_valid3_pulses", rv3_cnt - r0, 20);

    // Read on the capped cycle returns while the next grant rises.
    g0 = glog.size();
    for (int k = 0; k < 6; k++) push_op(2, 0, 1'b0, 400 + k, 0);
    push_op(1, 1, 1'b0, 450, 0);
    wait_idle("s5", 200);
    chk_glog("s5", g0, 2, 1, 2, 0, 3);
    if (g0 + 1 < rvlog.size()) chk("s5_rd_valid_at_handoff", rvlog[g0 + 1], 4'b0100);

    // Reset in the middle of a write burst.
    for (int k = 0; k < 8; k++) begin
      wd[k] = DW'($urandom);
      push_op(2, 0, 1'b1, 500 + k, wd[k]);
    end
    a0 = n_acc[2];
    n = 0;
    while (n < 100 && n_acc[2] < a0 + 3) begin @(negedge clk); n++; end
    chk("s6_burst_started", n < 100, 1'b1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("s6_gnt_after_rst", gnt, 0);
    chk("s6_mem_en_after_rst", mem_en, 0);
    chk("s6_rd_valid_after_rst", rd_valid, 0);
    chk("s6_busy_after_rst", busy, 0);
    @(negedge clk);
    chk("s6_regrant", gnt, 4'b0100);
    wait_idle("s6", 200);
    for (int k = 0; k < 8; k++) chk($sformatf("s6_ram[%0d]", 500 + k), ram_val(AW'(500 + k)), wd[k]);

    // Random contention across all requesters, disjoint address regions.
    for (int i = 0; i < NREQ; i++) begin
      for (int b = 0; b < 6; b++) begin
        n = $urandom_range(1, 10);
        for (int k = 0; k < n; k++)
          push_op(i, (k == 0) ? $urandom_range(0, 8) : 0, 1'($urandom_range(0, 1)),
                  600 + i * 100 + $urandom_range(0, 15), $urandom_range(0, 255));
      end
    end
    wait_idle("rand", 5000);
    for (int i = 0; i < NREQ; i++) chk($sformatf("rand_exp_q_empty[%0d]", i), exp_q[i].size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
